// File: rtl/fir_pkg.sv
// Shared constants and the round/saturate helper for the FIR output path.
// sat_round works at 64 bits so any IN_W < 64 / OUT_W < 64 pairing can reuse it.
package fir_pkg;

  localparam int BIT_PREC       = 16;
  localparam int OUT_SIZE       = 34;

  localparam int REQ_OUT_W      = BIT_PREC;
  localparam int REQ_FRAC_SHIFT = BIT_PREC - 1;
  localparam int REQ_DECIM      = 4;
  localparam int CNT_W          = 16;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } round_t;

  // Round half up, arithmetic shift right, then clamp to a signed out_w range.
  function automatic round_t sat_round(input logic signed [63:0] x,
                                       input int                 frac_shift,
                                       input int                 out_w);
    logic signed [63:0] t;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    round_t             r;
    t       = x + (64'sd1 <<< (frac_shift - 1));
    s       = t >>> frac_shift;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (out_w - 1));
    r.sat   = 1'b0;
    r.value = s;
    if (s > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (s < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_skid_fifo2.sv
// Two-entry valid/ready elastic buffer. Never stalls the writer: a push that
// cannot be stored is reported on drop and discarded.
module fir_skid_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         drop,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         pop;
  logic         accept;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign accept    = push && ((count != 2'd2) || pop);
  assign drop      = push && (count == 2'd2) && !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count gates out_data so stale words never show.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round/saturate to sample width, buffer two
// results for the FIFO and count drops and clipped samples.
module fir_out_requant #(
  parameter int IN_W       = fir_pkg::OUT_SIZE,
  parameter int OUT_W      = fir_pkg::REQ_OUT_W,
  parameter int FRAC_SHIFT = fir_pkg::REQ_FRAC_SHIFT,
  parameter int DECIM      = fir_pkg::REQ_DECIM,
  parameter int CNT_W      = fir_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             stat_clr,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  import fir_pkg::*;

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PH_W-1:0]  phase;
  logic             keep;
  logic [63:0]      in_ext;
  round_t           rq;
  logic             unused_rq_hi;

  logic             stage_valid;
  logic             stage_sat;
  logic [OUT_W-1:0] stage_data;
  logic             drop;

  assign keep   = in_valid && (phase == '0);
  assign in_ext = 64'(signed'(in_data));
  assign rq     = sat_round(in_ext, FRAC_SHIFT, OUT_W);
  // Clamped value always fits OUT_W; the upper bits are sign copies.
  assign unused_rq_hi = ^rq.value[63:OUT_W];

  // Phase advances only on valid input, so gaps do not disturb decimation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_sat   <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= keep;
      if (keep) begin
        stage_sat  <= rq.sat;
        stage_data <= rq.value[OUT_W-1:0];
      end
    end
  end

  fir_skid_fifo2 #(
    .W (OUT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stage_valid),
    .push_data (stage_data),
    .drop      (drop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Clear wins over a same-cycle event; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      sat_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else if (stat_clr) begin
      drop_cnt   <= '0;
      sat_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (drop) ovf_sticky <= 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      if (stage_valid && stage_sat && (sat_cnt != '1)) sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: one instance without decimation, one with DECIM=4,
// both driven alike and compared every cycle against a queue-based model.
module tb_fir_out_requant;

  localparam int IN_W  = 34;
  localparam int OUT_W = 16;
  localparam int FS    = 15;
  localparam int CW    = 16;

  localparam longint HALF  = 64'sd16384;
  localparam longint SCALE = 64'sd32768;
  localparam longint OMAX  = 64'sd32767;
  localparam longint OMIN  = -64'sd32768;
  localparam longint CMAX  = 64'sd65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_ready;
  logic             stat_clr;
  logic [1:0]       out_valid;
  logic [OUT_W-1:0] out_data [2];
  logic [1:0]       ovf_sticky;
  logic [CW-1:0]    drop_cnt [2];
  logic [CW-1:0]    sat_cnt  [2];

  fir_out_requant #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FS), .DECIM(1), .CNT_W(CW)
  ) u_dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
    .stat_clr(stat_clr), .ovf_sticky(ovf_sticky[0]),
    .drop_cnt(drop_cnt[0]), .sat_cnt(sat_cnt[0])
  );

  fir_out_requant #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAC_SHIFT(FS), .DECIM(4), .CNT_W(CW)
  ) u_dut_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
    .stat_clr(stat_clr), .ovf_sticky(ovf_sticky[1]),
    .drop_cnt(drop_cnt[1]), .sat_cnt(sat_cnt[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  int     decim_of [2] = '{1, 4};
  int     m_phase  [2];
  bit     m_sv     [2];
  longint m_sd     [2];
  bit     m_ss     [2];
  longint m_q      [2][$];
  longint m_drop   [2];
  longint m_sat    [2];
  bit     m_ovf    [2];
  longint seen     [2][$];

  // Floor((x + 0.5 LSB) / 2^FS), then clip to the signed OUT_W range.
  function automatic longint ref_round(input longint x, output bit sat);
    longint num;
    longint q;
    num = x + HALF;
    q   = num / SCALE;
    if ((num % SCALE) != 0 && num < 0) q = q - 1;
    sat = 1'b0;
    if (q > OMAX) begin
      sat = 1'b1;
      q   = OMAX;
    end else if (q < OMIN) begin
      sat = 1'b1;
      q   = OMIN;
    end
    return q;
  endfunction

  function automatic longint sdata(input int i);
    return longint'($signed(out_data[i]));
  endfunction

  task automatic model_edge(input bit iv, input longint d, input bit rdy, input bit clr);
    for (int i = 0; i < 2; i++) begin
      bit     drop_ev;
      bit     sat_ev;
      bit     s;
      longint v;
      if (!rst_n) begin
        m_phase[i] = 0;
        m_sv[i]    = 1'b0;
        m_ss[i]    = 1'b0;
        m_q[i].delete();
        m_drop[i]  = 0;
        m_sat[i]   = 0;
        m_ovf[i]   = 1'b0;
        continue;
      end
      drop_ev = 1'b0;
      if (m_q[i].size() > 0 && rdy) void'(m_q[i].pop_front());
      if (m_sv[i]) begin
        if (m_q[i].size() < 2) m_q[i].push_back(m_sd[i]);
        else drop_ev = 1'b1;
      end
      sat_ev = m_sv[i] && m_ss[i];
      if (clr) begin
        m_drop[i] = 0;
        m_sat[i]  = 0;
        m_ovf[i]  = 1'b0;
      end else begin
        if (drop_ev) m_ovf[i] = 1'b1;
        if (drop_ev && m_drop[i] < CMAX) m_drop[i]++;
        if (sat_ev && m_sat[i] < CMAX) m_sat[i]++;
      end
      m_sv[i] = iv && (m_phase[i] == 0);
      if (m_sv[i]) begin
        v       = ref_round(d, s);
        m_sd[i] = v;
        m_ss[i] = s;
      end
      if (iv) m_phase[i] = (m_phase[i] + 1) % decim_of[i];
    end
  endtask

  // Called at a negedge: drive inputs, compare outputs, take one clock edge.
  task automatic cycle(input bit iv, input longint d, input bit rdy, input bit clr);
    in_valid  = iv;
    in_data   = IN_W'(d);
    out_ready = rdy;
    stat_clr  = clr;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid[%0d]", i), longint'(out_valid[i]), longint'(m_q[i].size() > 0));
      check($sformatf("out_data[%0d]", i), sdata(i), (m_q[i].size() > 0) ? m_q[i][0] : 64'sd0);
      check($sformatf("drop_cnt[%0d]", i), longint'(drop_cnt[i]), m_drop[i]);
      check($sformatf("sat_cnt[%0d]", i), longint'(sat_cnt[i]), m_sat[i]);
      check($sformatf("ovf_sticky[%0d]", i), longint'(ovf_sticky[i]), longint'(m_ovf[i]));
      if (out_valid[i] && rdy) seen[i].push_back(sdata(i));
    end
    @(posedge clk);
    model_edge(iv, d, rdy, clr);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(1'b0, 0, rdy, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cycle(1'b0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  function automatic longint rand_sample();
    logic [IN_W-1:0] r;
    longint          k;
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 2 * 1048576)) - 64'sd1048576;
      1: begin
        r = IN_W'({$urandom, $urandom});
        return longint'($signed(r));
      end
      2: begin
        k = 64'sd1073725440 + longint'($urandom_range(0, 4)) - 64'sd2;
        return ($urandom_range(0, 1) == 1) ? k : -k - 64'sd32768;
      end
      default: begin
        k = longint'($urandom_range(0, 200)) - 64'sd100;
        return k * SCALE + HALF;
      end
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_edge(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), longint'(out_valid[i]), 0);
      check($sformatf("rst_out_data[%0d]", i), sdata(i), 0);
      check($sformatf("rst_drop_cnt[%0d]", i), longint'(drop_cnt[i]), 0);
    end

    // Rounding, two clocks after in_valid.
    cycle(1'b1, 64'sd49152, 1'b1, 1'b0);
    idle(1, 1'b1);
    check("round_1p5", sdata(0), 2);
    cycle(1'b1, -64'sd49152, 1'b1, 1'b0);
    idle(1, 1'b1);
    check("round_m1p5", sdata(0), -1);
    cycle(1'b1, 64'sd16383, 1'b1, 1'b0);
    idle(1, 1'b1);
    check("round_below_half", sdata(0), 0);
    check("round_below_half_valid", longint'(out_valid[0]), 1);
    idle(3, 1'b1);

    // Saturation.
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 64'sd2147483648, 1'b1, 1'b0);
    idle(1, 1'b1);
    check("sat_pos_data", sdata(0), 32767);
    check("sat_pos_cnt", longint'(sat_cnt[0]), 1);
    cycle(1'b1, -64'sd2147483648, 1'b1, 1'b0);
    idle(1, 1'b1);
    check("sat_neg_data", sdata(0), -32768);
    check("sat_neg_cnt", longint'(sat_cnt[0]), 2);
    check("sat_no_ovf", longint'(ovf_sticky[0]), 0);
    idle(3, 1'b1);

    // Decimation by 4, then with gaps.
    pulse_reset();
    seen[1].delete();
    for (int k = 0; k < 12; k++) cycle(1'b1, longint'(k) * SCALE, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("decim_count", longint'(seen[1].size()), 3);
    if (seen[1].size() == 3) begin
      check("decim_0", seen[1][0], 0);
      check("decim_1", seen[1][1], 4);
      check("decim_2", seen[1][2], 8);
    end
    seen[1].delete();
    for (int k = 20; k < 28; k++) begin
      cycle(1'b1, longint'(k) * SCALE, 1'b1, 1'b0);
      idle($urandom_range(0, 2), 1'b1);
    end
    idle(3, 1'b1);
    check("decim_gap_count", longint'(seen[1].size()), 2);
    if (seen[1].size() == 2) begin
      check("decim_gap_0", seen[1][0], 20);
      check("decim_gap_1", seen[1][1], 24);
    end

    // Overflow with the consumer stalled.
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int k = 100; k < 105; k++) cycle(1'b1, longint'(k) * SCALE, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("ovf_drop_cnt", longint'(drop_cnt[0]), 3);
    check("ovf_sticky", longint'(ovf_sticky[0]), 1);
    seen[0].delete();
    idle(3, 1'b1);
    check("ovf_out_count", longint'(seen[0].size()), 2);
    if (seen[0].size() == 2) begin
      check("ovf_out_0", seen[0][0], 100);
      check("ovf_out_1", seen[0][1], 101);
    end

    // Full buffer with streaming input and ready high.
    cycle(1'b1, 64'sd5 * SCALE, 1'b0, 1'b1);
    cycle(1'b1, 64'sd6 * SCALE, 1'b0, 1'b0);
    idle(1, 1'b0);
    seen[0].delete();
    for (int k = 0; k < 10; k++) cycle(1'b1, longint'(k + 40) * SCALE, 1'b1, 1'b0);
    check("stream_no_drop", longint'(drop_cnt[0]), 0);
    check("stream_rate", longint'(seen[0].size()), 10);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("clr_beats_drop", longint'(drop_cnt[0]), 0);
    cycle(1'b1, 64'sd9 * SCALE, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("drop_after_clr", longint'(drop_cnt[0]), 1);

    // Reset with samples buffered.
    check("pre_rst_full", longint'(out_valid[0]), 1);
    pulse_reset();
    check("post_rst_valid", longint'(out_valid[0]), 0);
    check("post_rst_drop", longint'(drop_cnt[0]), 0);
    check("post_rst_sat", longint'(sat_cnt[0]), 0);
    check("post_rst_ovf", longint'(ovf_sticky[0]), 0);
    cycle(1'b1, 64'sd7 * SCALE, 1'b1, 1'b0);
    idle(1, 1'b1);
    check("post_rst_first_d1", sdata(0), 7);
    check("post_rst_first_d4_valid", longint'(out_valid[1]), 1);
    check("post_rst_first_d4", sdata(1), 7);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 9) < 7, rand_sample(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
    idle(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
